// File: rtl/mypio_pkg.sv
// rtl/mypio_pkg.sv - shared register map, edge-mode enum and edge helper for mypio_in
package mypio_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_RAW      = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // True when the old->new transition of one bit is one the capture mode cares about.
    function automatic logic edge_match(edge_type_e mode, logic old_v, logic new_v);
        case (mode)
            EDGE_RISE: return !old_v && new_v;
            EDGE_FALL: return old_v && !new_v;
            default:   return old_v != new_v;
        endcase
    endfunction

endpackage

// File: rtl/mypio_in_if.sv
// rtl/mypio_in_if.sv - Avalon-MM slave bus bundle (address/read/write/writedata/readdata/irq)
//
// master: drives address, read, write, writedata; receives readdata, irq
// slave : receives address, read, write, writedata; drives readdata, irq
interface mypio_in_if;
    import mypio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;

    modport master (
        output address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/mypio_in_debounce.sv
// rtl/mypio_in_debounce.sv - one input bit: two-flop synchroniser plus filter register
//
// Optional feature macro: MYPIO_IN_DEBOUNCE_EN (per-bit stability counter).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   din          : asynchronous input bit
//   raw          : second synchroniser stage (unfiltered view)
//   filt         : accepted (filtered) value
//   load         : high in the cycle filt takes a new value (filt <= raw at next edge)
module mypio_in_debounce #(
    parameter logic IN_RESET        = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic raw,
    output logic filt,
    output logic load
);

    logic sync1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= IN_RESET;
            raw   <= IN_RESET;
        end else begin
            sync1 <= din;
            raw   <= sync1;
        end
    end

`ifdef MYPIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Accept only after raw has disagreed with filt for DEBOUNCE_CYCLES consecutive cycles.
    assign load = (raw != filt) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            filt <= IN_RESET;
        end else if (raw == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            filt <= raw;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_DEBOUNCE_CYCLES = DEBOUNCE_CYCLES;

    assign load = (raw != filt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt <= IN_RESET;
        end else begin
            filt <= raw;
        end
    end
`endif

endmodule

// File: rtl/mypio_in.sv
// rtl/mypio_in.sv - Avalon-MM input PIO with edge capture (W1C) and maskable level irq
//
// Optional feature macro: MYPIO_IN_DEBOUNCE_EN (per-bit debounce in mypio_in_debounce).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : Avalon-MM slave (address, read, write, writedata, readdata, irq)
//   conduit_in   : WIDTH asynchronous external inputs
// Registers: 0 DATA (ro), 1 IRQ_MASK (rw), 2 EDGE_CAPTURE (w1c), 3 RAW (ro).
module mypio_in
    import mypio_pkg::*;
#(
    parameter int              WIDTH           = 10,
    parameter logic [WIDTH-1:0] IN_RESET       = '0,
    parameter edge_type_e      EDGE_TYPE       = EDGE_ANY,
    parameter int              DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    mypio_in_if.slave        bus,
    input  logic [WIDTH-1:0] conduit_in
);

    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  load;
    logic [WIDTH-1:0]  edge_set;
    logic [WIDTH-1:0]  edge_clr;
    logic [WIDTH-1:0]  edge_capture;
    logic [WIDTH-1:0]  irq_mask;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] readdata_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mypio_in_debounce #(
            .IN_RESET        (IN_RESET[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (conduit_in[i]),
            .raw     (raw[i]),
            .filt    (data_q[i]),
            .load    (load[i])
        );
    end

    if (WIDTH < DATA_W) begin : g_unused_wdata
        logic unused_wdata;
        assign unused_wdata = ^bus.writedata[DATA_W-1:WIDTH];
    end

    // Edges are judged on the value about to enter data_q against its current value.
    always_comb begin
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_set[i] = load[i] && edge_match(EDGE_TYPE, data_q[i], raw[i]);
        end
    end

    assign edge_clr = (bus.write && bus.address == ADDR_EDGE_CAP) ? bus.writedata[WIDTH-1:0]
                                                                 : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:     rd_mux = DATA_W'(data_q);
            ADDR_IRQ_MASK: rd_mux = DATA_W'(irq_mask);
            ADDR_EDGE_CAP: rd_mux = DATA_W'(edge_capture);
            ADDR_RAW:      rd_mux = DATA_W'(raw);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata_q   <= '0;
        end else begin
            if (bus.write && bus.address == ADDR_IRQ_MASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            // A fresh edge beats a simultaneous clear of the same bit.
            edge_capture <= (edge_capture & ~edge_clr) | edge_set;
            if (bus.read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_mypio_in.sv
// tb/tb_mypio_in.sv - directed self-checking bench for mypio_in (EDGE_ANY and EDGE_FALL instances)
module tb_mypio_in;
    import mypio_pkg::*;

    localparam int W  = 4;
    localparam int DC = 4;
`ifdef MYPIO_IN_DEBOUNCE_EN
    localparam int LAT = 2 + DC;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] conduit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mypio_in_if bus_a ();
    mypio_in_if bus_f ();

    assign bus_f.address   = bus_a.address;
    assign bus_f.read      = bus_a.read;
    assign bus_f.write     = bus_a.write;
    assign bus_f.writedata = bus_a.writedata;

    mypio_in #(
        .WIDTH(W), .IN_RESET(4'hF), .EDGE_TYPE(EDGE_ANY), .DEBOUNCE_CYCLES(DC)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .conduit_in(conduit)
    );

    mypio_in #(
        .WIDTH(W), .IN_RESET(4'hF), .EDGE_TYPE(EDGE_FALL), .DEBOUNCE_CYCLES(DC)
    ) dut_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus_f), .conduit_in(conduit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp_a,
                      input logic [31:0] exp_f, input string tag);
        bus_a.address = addr;
        bus_a.read    = 1'b1;
        tick();
        bus_a.read    = 1'b0;
        check({tag, "_any"},  bus_a.readdata, exp_a);
        check({tag, "_fall"}, bus_f.readdata, exp_f);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus_a.address   = addr;
        bus_a.writedata = data;
        bus_a.write     = 1'b1;
        tick();
        bus_a.write     = 1'b0;
    endtask

    task automatic chk_irq(input logic exp_a, input logic exp_f, input string tag);
        check({tag, "_irq_any"},  {31'd0, bus_a.irq}, {31'd0, exp_a});
        check({tag, "_irq_fall"}, {31'd0, bus_f.irq}, {31'd0, exp_f});
    endtask

    initial begin
        reset_n         = 1'b0;
        conduit         = 4'hF;
        bus_a.address   = 2'd0;
        bus_a.read      = 1'b0;
        bus_a.write     = 1'b0;
        bus_a.writedata = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_rdata_any",  bus_a.readdata, 32'h0);
        check("rst_rdata_fall", bus_f.readdata, 32'h0);
        chk_irq(1'b0, 1'b0, "rst");
        reset_n = 1'b1;
        rd(ADDR_DATA,     32'hF, 32'hF, "rst_data");
        rd(ADDR_EDGE_CAP, 32'h0, 32'h0, "rst_cap");
        rd(ADDR_IRQ_MASK, 32'h0, 32'h0, "rst_mask");
        rd(ADDR_RAW,      32'hF, 32'hF, "rst_raw");

        // Settle inputs at 0 and clear the falls that produced
        conduit = 4'h0;
        repeat (LAT + 2) tick();
        rd(ADDR_EDGE_CAP, 32'hF, 32'hF, "fall_all_cap");
        wr(ADDR_EDGE_CAP, 32'hF);
        rd(ADDR_EDGE_CAP, 32'h0, 32'h0, "clr_all_cap");

        // Latency: data_q changes exactly LAT edges after the drive
        conduit = 4'h5;
        repeat (LAT - 1) tick();
        rd(ADDR_DATA,     32'h0, 32'h0, "lat_data_early");
        chk_irq(1'b0, 1'b0, "lat_masked");
        rd(ADDR_DATA,     32'h5, 32'h5, "lat_data");
        rd(ADDR_EDGE_CAP, 32'h5, 32'h0, "lat_cap");
        rd(ADDR_RAW,      32'h5, 32'h5, "lat_raw");

        // Unmask a pending bit, then clear it
        wr(ADDR_IRQ_MASK, 32'h1);
        chk_irq(1'b1, 1'b0, "unmask");
        rd(ADDR_IRQ_MASK, 32'h1, 32'h1, "mask_rb");
        wr(ADDR_EDGE_CAP, 32'h1);
        chk_irq(1'b0, 1'b0, "w1c0");
        rd(ADDR_EDGE_CAP, 32'h4, 32'h0, "w1c0_cap");

        // New edge on bit 0 raises irq the cycle it is captured
        conduit = 4'h4;
        repeat (LAT - 1) tick();
        chk_irq(1'b0, 1'b0, "b0_early");
        tick();
        chk_irq(1'b1, 1'b1, "b0_fall");
        rd(ADDR_EDGE_CAP, 32'h5, 32'h1, "b0_cap");
        wr(ADDR_EDGE_CAP, 32'h1);
        chk_irq(1'b0, 1'b0, "b0_clr");
        rd(ADDR_EDGE_CAP, 32'h4, 32'h0, "b0_clr_cap");

        // Collision: W1C of bit 1 on the edge that captures a new bit-1 edge
        wr(ADDR_IRQ_MASK, 32'h2);
        conduit = 4'h6;
        repeat (LAT) tick();
        chk_irq(1'b1, 1'b0, "b1_rise");
        conduit = 4'h4;
        repeat (LAT - 1) tick();
        wr(ADDR_EDGE_CAP, 32'h2);
        chk_irq(1'b1, 1'b1, "collide");
        rd(ADDR_EDGE_CAP, 32'h6, 32'h2, "collide_cap");

        // Read and write in the same cycle return the pre-write value
        bus_a.address   = ADDR_EDGE_CAP;
        bus_a.writedata = 32'hF;
        bus_a.read      = 1'b1;
        bus_a.write     = 1'b1;
        tick();
        bus_a.read  = 1'b0;
        bus_a.write = 1'b0;
        check("rw_same_any",  bus_a.readdata, 32'h6);
        check("rw_same_fall", bus_f.readdata, 32'h2);
        rd(ADDR_EDGE_CAP, 32'h0, 32'h0, "rw_after_cap");
        chk_irq(1'b0, 1'b0, "rw_after");

        // DATA is read-only
        wr(ADDR_DATA, 32'hF);
        rd(ADDR_DATA, 32'h4, 32'h4, "data_ro");

        // Edge type on bit 3: 0->1, 1->0, 0->1
        conduit = 4'hC;
        repeat (LAT + 1) tick();
        rd(ADDR_EDGE_CAP, 32'h8, 32'h0, "b3_rise");
        wr(ADDR_EDGE_CAP, 32'hF);
        conduit = 4'h4;
        repeat (LAT + 1) tick();
        rd(ADDR_EDGE_CAP, 32'h8, 32'h8, "b3_fall");
        wr(ADDR_EDGE_CAP, 32'hF);
        conduit = 4'hC;
        repeat (LAT + 1) tick();
        rd(ADDR_EDGE_CAP, 32'h8, 32'h0, "b3_rise2");
        wr(ADDR_EDGE_CAP, 32'hF);

`ifdef MYPIO_IN_DEBOUNCE_EN
        // A pulse one cycle shorter than DC never reaches data_q
        conduit = 4'hD;
        repeat (DC - 1) tick();
        conduit = 4'hC;
        repeat (12) tick();
        rd(ADDR_DATA,     32'hC, 32'hC, "glitch_data");
        rd(ADDR_EDGE_CAP, 32'h0, 32'h0, "glitch_cap");
`endif

        // Reset mid-operation
        wr(ADDR_IRQ_MASK, 32'hF);
        conduit = 4'h0;
        repeat (LAT + 2) tick();
        chk_irq(1'b1, 1'b1, "pre_rst");
        rd(ADDR_EDGE_CAP, 32'hC, 32'hC, "pre_rst_cap");
        reset_n = 1'b0;
        tick();
        check("mid_rst_rdata_any",  bus_a.readdata, 32'h0);
        check("mid_rst_rdata_fall", bus_f.readdata, 32'h0);
        chk_irq(1'b0, 1'b0, "mid_rst");
        reset_n = 1'b1;
        rd(ADDR_DATA,     32'hF, 32'hF, "post_rst_data");
        rd(ADDR_EDGE_CAP, 32'h0, 32'h0, "post_rst_cap");
        rd(ADDR_IRQ_MASK, 32'h0, 32'h0, "post_rst_mask");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
